// File: rtl/lights_pkg.sv
// Shared definitions for the exterior lighting blocks: mode encoding and default timing.
package lights_pkg;

    localparam int unsigned MODE_W          = 3;
    localparam int unsigned BLINK_W         = 4;
    localparam int unsigned HALF_PERIOD_DEF = 25_000_000;
    localparam int unsigned TAP_TICKS_DEF   = 12_500_000;

    typedef enum logic [MODE_W-1:0] {
        M_IDLE   = 3'd0,
        M_LEFT   = 3'd1,
        M_RIGHT  = 3'd2,
        M_HAZARD = 3'd3,
        M_COMF_L = 3'd4,
        M_COMF_R = 3'd5
    } mode_e;

endpackage

// File: rtl/blink_timebase.sv
// Half-period counter and lamp phase shared by every blinking mode.
module blink_timebase #(
    parameter int unsigned HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic restart,
    output logic phase,
    output logic toggle,
    output logic on_end
);

    localparam int unsigned CNT_W = $clog2(HALF_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             phase_q;

    // toggle/on_end look only at registered state so the FSM can use them without a loop
    assign toggle = run && (cnt_q == CNT_LAST);
    assign on_end = toggle && phase_q;
    assign phase  = phase_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (restart) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else if (run) begin
            if (toggle) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end
    end

endmodule

// File: rtl/turn_signal_ctrl.sv
// Turn indicator controller: steady, hazard and comfort (tap) blinking plus buzzer click.
module turn_signal_ctrl
    import lights_pkg::*;
#(
    parameter int unsigned HALF_PERIOD    = HALF_PERIOD_DEF,
    parameter int unsigned TAP_TICKS      = TAP_TICKS_DEF,
    parameter int unsigned COMFORT_BLINKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lever_left,
    input  logic       lever_right,
    input  logic       sw_hazard,
    output logic       turn_left,
    output logic       turn_right,
    output logic       click,
    output logic [2:0] mode
);

    localparam int unsigned HOLD_W = $clog2(TAP_TICKS + 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(TAP_TICKS);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(COMFORT_BLINKS - 1);

    logic lev_l, lev_r;
    logic lev_l_q, lev_r_q;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    mode_e mode_q, mode_d;
    logic turn_left_q, turn_right_q, click_q;
    logic run, restart, phase, toggle, on_end, lamp_phase;

    assign lev_l = lever_left & ~lever_right;
    assign lev_r = lever_right & ~lever_left;

    assign run        = (mode_q != M_IDLE);
    assign restart    = (mode_q == M_IDLE) && (mode_d != M_IDLE);
    assign lamp_phase = restart ? 1'b1 : (phase ^ toggle);

    blink_timebase #(.HALF_PERIOD(HALF_PERIOD)) u_timebase (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .restart (restart),
        .phase   (phase),
        .toggle  (toggle),
        .on_end  (on_end)
    );

    // Lever hold length, used to tell a tap from a steady hold
    always_comb begin
        hold_d = hold_q;
        if ((lev_l && !lev_l_q) || (lev_r && !lev_r_q)) begin
            hold_d = '0;
        end else if ((lev_l || lev_r) && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    always_comb begin
        mode_d  = mode_q;
        blink_d = blink_q;
        if (sw_hazard) begin
            mode_d  = M_HAZARD;
            blink_d = '0;
        end else begin
            case (mode_q)
                M_IDLE: begin
                    if (lev_l)      mode_d = M_LEFT;
                    else if (lev_r) mode_d = M_RIGHT;
                end
                M_LEFT: begin
                    if (lev_l_q && !lev_l) begin
                        blink_d = '0;
                        mode_d  = (hold_q < HOLD_MAX) ? M_COMF_L : M_IDLE;
                    end else if (lev_r) begin
                        mode_d = M_RIGHT;
                    end else if (!lev_l) begin
                        mode_d = M_IDLE;
                    end
                end
                M_RIGHT: begin
                    if (lev_r_q && !lev_r) begin
                        blink_d = '0;
                        mode_d  = (hold_q < HOLD_MAX) ? M_COMF_R : M_IDLE;
                    end else if (lev_l) begin
                        mode_d = M_LEFT;
                    end else if (!lev_r) begin
                        mode_d = M_IDLE;
                    end
                end
                M_HAZARD: begin
                    blink_d = '0;
                    if (lev_l)      mode_d = M_LEFT;
                    else if (lev_r) mode_d = M_RIGHT;
                    else            mode_d = M_IDLE;
                end
                M_COMF_L, M_COMF_R: begin
                    // The ON half running at the tap is the first comfort blink
                    if (on_end && (blink_q == BLINK_LAST)) begin
                        mode_d  = M_IDLE;
                        blink_d = '0;
                    end else if (lev_l) begin
                        mode_d  = M_LEFT;
                        blink_d = '0;
                    end else if (lev_r) begin
                        mode_d  = M_RIGHT;
                        blink_d = '0;
                    end else if (on_end) begin
                        blink_d = blink_q + BLINK_W'(1);
                    end
                end
                default: begin
                    mode_d  = M_IDLE;
                    blink_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= M_IDLE;
            blink_q      <= '0;
            hold_q       <= '0;
            lev_l_q      <= 1'b0;
            lev_r_q      <= 1'b0;
            turn_left_q  <= 1'b0;
            turn_right_q <= 1'b0;
            click_q      <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            blink_q      <= blink_d;
            hold_q       <= hold_d;
            lev_l_q      <= lev_l;
            lev_r_q      <= lev_r;
            turn_left_q  <= lamp_phase && (mode_d == M_LEFT  || mode_d == M_COMF_L || mode_d == M_HAZARD);
            turn_right_q <= lamp_phase && (mode_d == M_RIGHT || mode_d == M_COMF_R || mode_d == M_HAZARD);
            click_q      <= restart || (toggle && (mode_d != M_IDLE));
        end
    end

    assign turn_left  = turn_left_q;
    assign turn_right = turn_right_q;
    assign click      = click_q;
    assign mode       = mode_q;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Directed bench for turn_signal_ctrl with HALF_PERIOD=4, TAP_TICKS=3, COMFORT_BLINKS=3.
module tb_turn_signal_ctrl;

    logic       clk = 1'b0;
    logic       rst, lever_left, lever_right, sw_hazard;
    logic       turn_left, turn_right, click;
    logic [2:0] mode;

    int nchecks = 0;
    int nerrors = 0;

    turn_signal_ctrl #(
        .HALF_PERIOD   (4),
        .TAP_TICKS     (3),
        .COMFORT_BLINKS(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lever_left (lever_left),
        .lever_right(lever_right),
        .sw_hazard  (sw_hazard),
        .turn_left  (turn_left),
        .turn_right (turn_right),
        .click      (click),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, ll, lr, hz;
        logic [5:0] exp;  // {turn_left, turn_right, click, mode}
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic r, input logic ll, input logic lr, input logic hz,
                                input logic tl, input logic tr, input logic ck, input logic [2:0] md);
        vec_t v;
        v.r = r; v.ll = ll; v.lr = lr; v.hz = hz;
        v.exp = {tl, tr, ck, md};
        vq.push_back(v);
    endfunction

    task automatic drv(input logic r, input logic ll, input logic lr, input logic hz);
        rst = r; lever_left = ll; lever_right = lr; sw_hazard = hz;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [5:0] exp);
        logic [5:0] got;
        got = {turn_left, turn_right, click, mode};
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got tl/tr/ck/mode=%b expected %b", nm, got, exp);
        end
    endtask

    initial begin
        drv(1'b1, 1'b1, 1'b1, 1'b1);

        // Reset with all inputs high, then release with inputs low
        add(1, 1, 1, 1, 0, 0, 0, 3'd0);
        add(1, 1, 1, 1, 0, 0, 0, 3'd0);
        add(0, 0, 0, 0, 0, 0, 0, 3'd0);
        add(0, 0, 0, 0, 0, 0, 0, 3'd0);
        // Steady left for 20 cycles: 4 on, 4 off, click at each lamp edge
        for (int i = 0; i < 20; i++)
            add(0, 1, 0, 0, ((i / 4) % 2) == 0, 0, (i % 4) == 0, 3'd1);
        // Long hold released: straight to IDLE, no click
        add(0, 0, 0, 0, 0, 0, 0, 3'd0);
        add(0, 0, 0, 0, 0, 0, 0, 3'd0);
        // Comfort tap on the right: 2-cycle lever, 3 ON periods then IDLE
        for (int i = 0; i < 20; i++)
            add(0, 0, i < 2, 0, 0, ((i / 4) % 2) == 0, (i % 4) == 0, (i < 2) ? 3'd2 : 3'd5);
        add(0, 0, 0, 0, 0, 0, 0, 3'd0);
        add(0, 0, 0, 0, 0, 0, 0, 3'd0);
        add(0, 0, 0, 0, 0, 0, 0, 3'd0);
        // Both levers high is ignored
        for (int i = 0; i < 3; i++)
            add(0, 1, 1, 0, 0, 0, 0, 3'd0);
        add(0, 0, 0, 0, 0, 0, 0, 3'd0);

        foreach (vq[i]) begin
            drv(vq[i].r, vq[i].ll, vq[i].lr, vq[i].hz);
            cyc();
            chk($sformatf("vec%0d", i), vq[i].exp);
        end

        // Hazard raised mid-ON-half of LEFT, then dropped with lever still held
        drv(0, 1, 0, 0); cyc(); chk("hz_left_e1", {3'b101, 3'd1});
        cyc();                  chk("hz_left_e2", {3'b100, 3'd1});
        drv(0, 1, 0, 1); cyc(); chk("hz_on_e3",   {3'b110, 3'd3});
        cyc();                  chk("hz_on_e4",   {3'b110, 3'd3});
        cyc();                  chk("hz_off_e5",  {3'b001, 3'd3});
        drv(0, 1, 0, 0); cyc(); chk("hz_drop_e6", {3'b000, 3'd1});
        cyc();                  chk("hz_drop_e7", {3'b000, 3'd1});
        cyc();                  chk("hz_drop_e8", {3'b000, 3'd1});
        cyc();                  chk("hz_drop_e9", {3'b101, 3'd1});
        drv(0, 0, 0, 0); cyc(); chk("hz_release", {3'b000, 3'd0});
        cyc();

        // Tap left into COMF_L, then cancel with the right lever
        drv(0, 1, 0, 0); cyc(); chk("cl_e1", {3'b101, 3'd1});
        cyc();                  chk("cl_e2", {3'b100, 3'd1});
        drv(0, 0, 0, 0); cyc(); chk("cl_comf", {3'b100, 3'd4});
        drv(0, 0, 1, 0); cyc(); chk("cl_cancel", {3'b010, 3'd2});
        cyc();                  chk("cl_right_toggle", {3'b001, 3'd2});
        drv(0, 0, 0, 0); cyc(); chk("cl_right_tap", {3'b000, 3'd5});
        for (int k = 0; k < 40 && mode != 3'd0; k++) cyc();
        chk("cl_comf_r_expire", {3'b000, 3'd0});
        cyc();
        chk("cl_idle_quiet", {3'b000, 3'd0});

        // Reset pulse during hazard ON, then re-entry with restart
        drv(0, 0, 0, 1); cyc(); chk("rst_hz_e1", {3'b111, 3'd3});
        cyc();                  chk("rst_hz_e2", {3'b110, 3'd3});
        drv(1, 0, 0, 1); cyc(); chk("rst_pulse", {3'b000, 3'd0});
        drv(0, 0, 0, 1); cyc(); chk("rst_reentry", {3'b111, 3'd3});
        cyc();                  chk("rst_reentry2", {3'b110, 3'd3});
        drv(0, 0, 0, 0); cyc(); chk("rst_hz_off", {3'b000, 3'd0});

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
